cache_fill_ctrl: RTL and testbench

- Direct-mapped cache controller; the initiator that drives the per-line valid-bit RAM, tag RAM and data RAM.
- Accepts CPU read requests and performs lookup through the valid/tag RAMs, which have a 1-cycle registered read.
- On a miss, fetches the word from memory over a req/ack handshake, fills the line, then returns the data.
- Also sequences whole-cache invalidation after reset and on a flush request.

---
 rtl/cache_fill_ctrl.sv | 109 ++++++++++
 tb/tb_cache_fill_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: direct-mapped read-only cache controller driving valid/tag/data RAMs,
// with miss fill over a memory req/ack handshake and whole-cache invalidation.
module cache_fill_ctrl #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 8,
    parameter int DATA_W  = 32
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     CpuReq,
    input  logic [TAG_W+INDEX_W-1:0] CpuAddr,
    output logic                     CpuReady,
    output logic [DATA_W-1:0]        CpuData,
    input  logic                     FlushReq,
    output logic                     FlushDone,
    output logic [INDEX_W-1:0]       VAddress,
    output logic                     VValidIn,
    output logic                     VWrite,
    output logic                     VReset,
    input  logic                     VValidOut,
    output logic [TAG_W-1:0]         TagIn,
    output logic                     TagWrite,
    input  logic [TAG_W-1:0]         TagOut,
    output logic [DATA_W-1:0]        DataIn,
    output logic                     DataWrite,
    input  logic [DATA_W-1:0]        DataOut,
    output logic                     MemReq,
    output logic [TAG_W+INDEX_W-1:0] MemAddr,
    input  logic                     MemAck,
    input  logic [DATA_W-1:0]        MemData
);
    localparam int AW = TAG_W + INDEX_W;

    typedef enum logic [2:0] {INIT, IDLE, READ, COMPARE, MISS, FILL, DONE, FLUSH} state_t;

    state_t            state, state_nx;
    logic [AW-1:0]     addr_q;
    logic [DATA_W-1:0] fill_q;
    logic              hit;

    assign VAddress = addr_q[INDEX_W-1:0];
    assign TagIn    = addr_q[AW-1:INDEX_W];
    assign MemAddr  = addr_q;
    assign DataIn   = fill_q;
    assign hit      = VValidOut && (TagOut == addr_q[AW-1:INDEX_W]);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= INIT;
            addr_q <= '0;
            fill_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && !FlushReq && CpuReq)
                addr_q <= CpuAddr;
            if (state == MISS && MemAck)
                fill_q <= MemData;
        end
    end

    // Every strobe is a pure decode of the state, so reset silences MemReq at once.
    always_comb begin
        state_nx  = state;
        CpuReady  = 1'b0;
        CpuData   = '0;
        FlushDone = 1'b0;
        VValidIn  = 1'b0;
        VWrite    = 1'b0;
        VReset    = 1'b0;
        TagWrite  = 1'b0;
        DataWrite = 1'b0;
        MemReq    = 1'b0;
        case (state)
            INIT: begin
                VReset   = 1'b1;
                state_nx = IDLE;
            end
            IDLE:    state_nx = FlushReq ? FLUSH : (CpuReq ? READ : IDLE);
            READ:    state_nx = COMPARE;
            COMPARE: begin
                CpuReady = hit;
                CpuData  = hit ? DataOut : '0;
                state_nx = hit ? IDLE : MISS;
            end
            MISS: begin
                MemReq   = 1'b1;
                state_nx = MemAck ? FILL : MISS;
            end
            FILL: begin
                VWrite    = 1'b1;
                VValidIn  = 1'b1;
                TagWrite  = 1'b1;
                DataWrite = 1'b1;
                state_nx  = DONE;
            end
            DONE: begin
                CpuReady = 1'b1;
                CpuData  = fill_q;
                state_nx = IDLE;
            end
            FLUSH: begin
                VReset    = 1'b1;
                FlushDone = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = INIT;
        endcase
    end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: scoreboard bench for cache_fill_ctrl with behavioural valid/tag/data RAMs
// and a memory responder whose ack delay is chosen per request.
module tb_cache_fill_ctrl;
    localparam int IW = 6;
    localparam int TW = 8;
    localparam int DW = 32;
    localparam int AW = TW + IW;

    logic          Clk, Reset, CpuReq, CpuReady, FlushReq, FlushDone;
    logic [AW-1:0] CpuAddr, MemAddr;
    logic [DW-1:0] CpuData, DataIn, DataOut, MemData;
    logic [IW-1:0] VAddress;
    logic          VValidIn, VWrite, VReset, VValidOut, TagWrite, DataWrite, MemReq, MemAck;
    logic [TW-1:0] TagIn, TagOut;

    logic          vram [64];
    logic [TW-1:0] tram [64];
    logic [DW-1:0] dram [64];

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] sb [$];

    cache_fill_ctrl #(.INDEX_W(IW), .TAG_W(TW), .DATA_W(DW)) dut (
        .Clk(Clk), .Reset(Reset), .CpuReq(CpuReq), .CpuAddr(CpuAddr),
        .CpuReady(CpuReady), .CpuData(CpuData), .FlushReq(FlushReq), .FlushDone(FlushDone),
        .VAddress(VAddress), .VValidIn(VValidIn), .VWrite(VWrite), .VReset(VReset),
        .VValidOut(VValidOut), .TagIn(TagIn), .TagWrite(TagWrite), .TagOut(TagOut),
        .DataIn(DataIn), .DataWrite(DataWrite), .DataOut(DataOut), .MemReq(MemReq),
        .MemAddr(MemAddr), .MemAck(MemAck), .MemData(MemData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // RAMs with registered read: data for VAddress appears one cycle later.
    always_ff @(posedge Clk) begin
        if (VReset)
            for (int i = 0; i < 64; i++) vram[i] <= 1'b0;
        else if (VWrite)
            vram[VAddress] <= VValidIn;
        if (TagWrite)  tram[VAddress] <= TagIn;
        if (DataWrite) dram[VAddress] <= DataIn;
        VValidOut <= vram[VAddress];
        TagOut    <= tram[VAddress];
        DataOut   <= dram[VAddress];
    end

    task automatic test_reset();
        Reset = 1'b1; CpuReq = 1'b0; CpuAddr = '0; FlushReq = 1'b0; MemAck = 1'b0; MemData = '0;
        repeat (3) @(negedge Clk);
        n_checks++;
        if ({MemReq, CpuReady, CpuData, FlushDone, VWrite, TagWrite, DataWrite} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: MemReq=%b CpuReady=%b CpuData=%h FlushDone=%b writes=%b%b%b, all must be 0",
                     MemReq, CpuReady, CpuData, FlushDone, VWrite, TagWrite, DataWrite);
        end
        Reset = 1'b0;
        #1;
        n_checks++;
        if (VReset !== 1'b1) begin
            n_fail++;
            $display("FAIL init_vreset: VReset=%b expected 1", VReset);
        end
        @(negedge Clk);
        n_checks++;
        if ({VReset, FlushDone} !== 2'b00) begin
            n_fail++;
            $display("FAIL init_one_cycle: VReset=%b FlushDone=%b expected 0 0", VReset, FlushDone);
        end
    endtask

    // Issues one read; d is the number of MemReq cycles before the ack, so a miss
    // spends d+1 cycles in MISS and returns 4+d+1 cycles after the request cycle.
    task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] word,
                           input bit exp_hit, input int d, input string name);
        int            cyc, w, lat;
        bit            mem_seen, done;
        logic [DW-1:0] exp;
        cyc = 0; w = 0; mem_seen = 0; done = 0;
        lat = exp_hit ? 2 : 5 + d;
        @(negedge Clk);
        CpuReq = 1'b1; CpuAddr = addr;
        sb.push_back(word);
        while (!done && cyc < 40) begin
            @(negedge Clk);
            cyc++;
            CpuReq = 1'b0; MemAck = 1'b0;
            if (MemReq) begin
                if (!mem_seen) begin
                    n_checks++;
                    if (MemAddr !== addr) begin
                        n_fail++;
                        $display("FAIL %s_memaddr: MemAddr=%h expected %h", name, MemAddr, addr);
                    end
                end
                mem_seen = 1;
                if (w == d) begin
                    MemAck = 1'b1; MemData = word;
                end
                w++;
            end
            if (DataWrite) begin
                n_checks++;
                if (exp_hit || {VAddress, TagIn, DataIn, VValidIn, VWrite, TagWrite, VReset} !==
                               {addr[IW-1:0], addr[AW-1:IW], word, 4'b1110}) begin
                    n_fail++;
                    $display("FAIL %s_fill: idx=%h tag=%h data=%h vin=%b vw=%b tw=%b vr=%b expected idx=%h tag=%h data=%h 1 1 1 0 (hit=%0d)",
                             name, VAddress, TagIn, DataIn, VValidIn, VWrite, TagWrite, VReset,
                             addr[IW-1:0], addr[AW-1:IW], word, exp_hit);
                end
            end
            if (CpuReady) begin
                done = 1;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s_data: CpuReady with CpuData=%h but nothing expected", name, CpuData);
                end else begin
                    exp = sb.pop_front();
                    if (CpuData !== exp) begin
                        n_fail++;
                        $display("FAIL %s_data: CpuData=%h expected %h", name, CpuData, exp);
                    end
                end
                n_checks++;
                if (cyc != lat || mem_seen == exp_hit) begin
                    n_fail++;
                    $display("FAIL %s_latency: ready at cycle %0d memreq_seen=%0d expected cycle %0d memreq_seen=%0d",
                             name, cyc, mem_seen, lat, !exp_hit);
                end
            end else if (CpuData !== '0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s_data_idle: CpuData=%h while CpuReady=0, expected 0", name, CpuData);
            end
        end
        MemAck = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no CpuReady within 40 cycles, expected at cycle %0d", name, lat);
            sb.delete();
        end
    endtask

    task automatic test_miss_hit();
        do_read(14'h0A05, 32'hDEADBEEF, 1'b0, 3, "cold_miss");
        do_read(14'h0A05, 32'hDEADBEEF, 1'b1, 0, "hit");
    endtask

    task automatic test_conflict();
        do_read(14'h1205, 32'h12345678, 1'b0, 1, "conflict_miss");
        do_read(14'h1205, 32'h12345678, 1'b1, 0, "conflict_hit");
        do_read(14'h0A05, 32'hCAFEF00D, 1'b0, 2, "evicted_miss");
    endtask

    task automatic test_flush();
        @(negedge Clk);
        FlushReq = 1'b1; CpuReq = 1'b1; CpuAddr = 14'h1205;
        @(negedge Clk);
        FlushReq = 1'b0; CpuReq = 1'b0;
        n_checks++;
        if ({VReset, FlushDone, MemReq, VWrite} !== 4'b1100) begin
            n_fail++;
            $display("FAIL flush_pulse: VReset=%b FlushDone=%b MemReq=%b VWrite=%b expected 1 1 0 0",
                     VReset, FlushDone, MemReq, VWrite);
        end
        @(negedge Clk);
        n_checks++;
        if ({VReset, FlushDone, CpuReady} !== 3'b000) begin
            n_fail++;
            $display("FAIL flush_end: VReset=%b FlushDone=%b CpuReady=%b expected 0 0 0",
                     VReset, FlushDone, CpuReady);
        end
        do_read(14'h0A05, 32'h5555AAAA, 1'b0, 0, "post_flush_a");
        do_read(14'h1205, 32'h600DD00D, 1'b0, 1, "post_flush_b");
    endtask

    task automatic test_reset_mid_miss();
        int n;
        n = 0;
        @(negedge Clk);
        CpuReq = 1'b1; CpuAddr = 14'h1207;
        while (!MemReq && n < 10) begin
            @(negedge Clk);
            CpuReq = 1'b0;
            n++;
        end
        n_checks++;
        if (MemReq !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_reach_miss: MemReq=%b after %0d cycles expected 1", MemReq, n);
        end
        #2 Reset = 1'b1;
        #1;
        n_checks++;
        if (MemReq !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_async: MemReq=%b right after reset expected 0", MemReq);
        end
        repeat (2) begin
            @(negedge Clk);
            n_checks++;
            if ({CpuReady, DataWrite, MemReq} !== 3'b000) begin
                n_fail++;
                $display("FAIL abort_quiet: CpuReady=%b DataWrite=%b MemReq=%b expected 0 0 0",
                         CpuReady, DataWrite, MemReq);
            end
        end
        Reset = 1'b0; MemAck = 1'b1; MemData = 32'hBAADBAAD;
        #1;
        n_checks++;
        if (VReset !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_init: VReset=%b expected 1", VReset);
        end
        repeat (2) begin
            @(negedge Clk);
            n_checks++;
            if ({VReset, CpuReady, DataWrite, MemReq} !== 4'b0000) begin
                n_fail++;
                $display("FAIL stray_ack: VReset=%b CpuReady=%b DataWrite=%b MemReq=%b expected 0 0 0 0",
                         VReset, CpuReady, DataWrite, MemReq);
            end
        end
        MemAck = 1'b0;
        do_read(14'h1205, 32'hA1B2C3D4, 1'b0, 0, "after_abort");
    endtask

    task automatic test_back_to_back();
        do_read(14'h2A09, 32'h0BADF00D, 1'b0, 0, "same_cycle_ack");
        do_read(14'h2A09, 32'h0BADF00D, 1'b1, 0, "b2b_hit_a");
        do_read(14'h1205, 32'hA1B2C3D4, 1'b1, 0, "b2b_hit_b");
        do_read(14'h3F3F, 32'h89ABCDEF, 1'b0, 4, "slow_ack");
    endtask

    initial begin
        test_reset();
        test_miss_hit();
        test_conflict();
        test_flush();
        test_reset_mid_miss();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
